multi_cycle_control_unit: RTL and testbench
===========================================

Name: multi_cycle_control_unit

Overview:
- Moore-style FSM sequencing the RV32I multi-cycle datapath: one shared memory port, an IR/OldPC register pair, and registered ALUOut/Data.
- Decodes opcode/funct3/funct7 into mux selects, an ALU operation code and write enables.
- Branch resolution uses ALU comparison flags.
- Sits between the instruction register and the datapath muxes/register file of the processor top.

Parameters:
- none (all encodings are package constants)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- OpCode  in  7  Inst[6:0]
- funct3  in  3  Inst[14:12]
- funct7  in  7  Inst[31:25]
- Eq  in  1  ALU A==B
- Gt  in  1  ALU A>B signed
- GtU  in  1  ALU A>B unsigned
- PCWrite  out  1  load PC from Result
- AdrSrc  out  1  memory address: 0=PC, 1=Result
- MemWrite  out  1  store strobe
- IRWrite  out  1  latch Inst and OldPC
- ResultSrc  out  2  00=ALUOut (registered), 01=MemData register, 10=ALUResult (combinational)
- ALUControl  out  5  ALU operation
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=Reg1, 11=zero
- ALUSrcB  out  2  00=Reg2, 01=Imm, 10=constant 4
- RegWrite  out  1  register-file write enable

Behaviour:
- Outputs are combinational from state (plus flags in BRANCH).
- Defaults: all enables 0, selects 0, ALUControl=ADD.
- ALU codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
- reset high: next state FETCH; PCWrite/IRWrite/MemWrite/RegWrite forced 0 that cycle.
- FETCH: AdrSrc=0, IRWrite, SrcA=PC, SrcB=4, ADD, ResultSrc=10, PCWrite. Next: DECODE.
- DECODE: SrcA=OldPC, SrcB=Imm, ADD, so ALUOut holds the branch/JAL target. Next by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR1
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - any other -> FETCH (illegal = NOP, no writes)
- MEMADR: SrcA=Reg1, SrcB=Imm, ADD. Next: MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite. Next: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite. Next: FETCH.
- EXECR: SrcA=Reg1, SrcB=Reg2, op from funct3; funct7[5] selects SUB (f3=000) / SRA (f3=101). Next: ALUWB.
- EXECI: SrcA=Reg1, SrcB=Imm, op from funct3; f3=000 is always ADD; f3=101 uses funct7[5] for SRA/SRL. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite. Next: FETCH.
- JAL: SrcA=OldPC, SrcB=4, ADD, ResultSrc=00 (target), PCWrite. Next: ALUWB (writes OldPC+4).
- JALR1: SrcA=Reg1, SrcB=Imm, ADD. Next: JALR2.
- JALR2: SrcA=OldPC, SrcB=4, ADD, ResultSrc=00, PCWrite. Next: ALUWB. Target LSB is not cleared.
- BRANCH: SrcA=Reg1, SrcB=Reg2, SUB, ResultSrc=00. PCWrite=taken. Next: FETCH.
  - taken conditions: beq Eq; bne !Eq; blt !Gt&!Eq; bge Gt|Eq; bltu !GtU&!Eq; bgeu GtU|Eq
  - f3 010/011 never taken
- LUI: SrcA=zero, SrcB=Imm, ADD. Next: ALUWB.
- AUIPC: SrcA=OldPC, SrcB=Imm, ADD. Next: ALUWB.
- Cycle counts: load 5, store 4, R/I 4, branch 3, JAL 4, JALR 5, LUI/AUIPC 4.
- Reset mid-instruction aborts it; no partial write occurs after the reset edge.

Optional Feature:
- Macro: M_EXT_EN
- Defined: EXECR with funct7=0000001 maps funct3 0..7 to ALU codes 10..17: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Undefined: funct7=0000001 R-type is illegal; next state FETCH, RegWrite never asserted.

Decomposition:
- Package mc_cu_pkg holds:
  - opcode constants
  - state enum (4-bit)
  - ALU op codes
  - AdrSrc/ALUSrcA/ALUSrcB/ResultSrc encodings
- One sub-module, alu_decoder: (state class, funct3, funct7) -> ALUControl.

Test Plan:
- reset high 2 cycles, then low -> state FETCH; first cycle IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10, AdrSrc=0.
- lw 0x00412083 -> FETCH, DECODE, MEMADR, MEMREAD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1), then FETCH.
- sub 0x40208033 -> EXECR ALUControl=1, ALUWB RegWrite=1; srai 0x4010D093 -> EXECI ALUControl=7.
- beq 0x00208463: Eq=1 -> BRANCH PCWrite=1, ResultSrc=00; Eq=0 -> PCWrite=0; next FETCH both cases.
- jalr 0x000080E7 -> JALR1, JALR2 (PCWrite=1), ALUWB (RegWrite=1); opcode 0x7F -> DECODE then FETCH, no writes.
- sw 0x0020A023 -> MEMWRITE with MemWrite=1, AdrSrc=1; reset asserted in MEMADR -> MemWrite never pulses.

Source files
------------

// File: rtl/mc_cu_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit.
//   - opcode constants
//   - FSM state enum (4-bit)
//   - ALU operation codes
//   - datapath mux-select encodings (AdrSrc, ALUSrcA, ALUSrcB, ResultSrc)
//   - ALU decoder class selector and a branch-condition helper
package mc_cu_pkg;

    // Opcodes (Inst[6:0])
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    // funct7 value that marks an RV32M instruction
    localparam logic [6:0] Funct7MulDiv = 7'b0000001;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StJal,
        StJalr1,
        StJalr2,
        StBranch,
        StLui,
        StAuipc
    } state_t;

    // ALU operation codes
    localparam logic [4:0] AluAdd    = 5'd0;
    localparam logic [4:0] AluSub    = 5'd1;
    localparam logic [4:0] AluSll    = 5'd2;
    localparam logic [4:0] AluSlt    = 5'd3;
    localparam logic [4:0] AluSltu   = 5'd4;
    localparam logic [4:0] AluXor    = 5'd5;
    localparam logic [4:0] AluSrl    = 5'd6;
    localparam logic [4:0] AluSra    = 5'd7;
    localparam logic [4:0] AluOr     = 5'd8;
    localparam logic [4:0] AluAnd    = 5'd9;
    localparam logic [4:0] AluMulBase = 5'd10;  // MUL..REMU = 10..17, indexed by funct3

    // Memory address select
    localparam logic AdrPc     = 1'b0;
    localparam logic AdrResult = 1'b1;

    // ALU A-operand select
    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcAReg1  = 2'b10;
    localparam logic [1:0] SrcAZero  = 2'b11;

    // ALU B-operand select
    localparam logic [1:0] SrcBReg2 = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    // Result bus select
    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResMemData   = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    // How the ALU decoder should interpret funct3/funct7 in the current state
    typedef enum logic [1:0] {
        AluClsAdd,
        AluClsSub,
        AluClsR,
        AluClsI
    } alu_class_t;

    // Branch outcome from ALU comparison flags; funct3 010/011 are not branches.
    function automatic logic branch_taken(input logic [2:0] f3, input logic eq,
                                          input logic gt, input logic gtu);
        logic taken;
        case (f3)
            3'b000:  taken = eq;
            3'b001:  taken = !eq;
            3'b100:  taken = !gt && !eq;
            3'b101:  taken = gt || eq;
            3'b110:  taken = !gtu && !eq;
            3'b111:  taken = gtu || eq;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder for the multi-cycle control unit.
// Build option: M_EXT_EN enables RV32M codes (MUL..REMU) for funct7=0000001 R-type.
// Ports:
//   alu_class  in  2  how to interpret funct3/funct7 (fixed ADD/SUB, R-type, I-type)
//   funct3     in  3  Inst[14:12]
//   funct7     in  7  Inst[31:25]
//   ALUControl out 5  ALU operation code
module alu_decoder
    import mc_cu_pkg::*;
(
    input  alu_class_t  alu_class,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output logic [4:0]  ALUControl
);

    logic is_muldiv;
    logic alt;  // funct7[5]: SUB / SRA selector

    assign is_muldiv = (funct7 == Funct7MulDiv);
    assign alt       = funct7[5];

    always_comb begin
        ALUControl = AluAdd;
        case (alu_class)
            AluClsAdd: ALUControl = AluAdd;
            AluClsSub: ALUControl = AluSub;
            AluClsR, AluClsI: begin
                case (funct3)
                    3'b000:  ALUControl = (alu_class == AluClsR && alt) ? AluSub : AluAdd;
                    3'b001:  ALUControl = AluSll;
                    3'b010:  ALUControl = AluSlt;
                    3'b011:  ALUControl = AluSltu;
                    3'b100:  ALUControl = AluXor;
                    3'b101:  ALUControl = alt ? AluSra : AluSrl;
                    3'b110:  ALUControl = AluOr;
                    default: ALUControl = AluAnd;
                endcase
                if (alu_class == AluClsR && is_muldiv) begin
`ifdef M_EXT_EN
                    ALUControl = AluMulBase + {2'b00, funct3};
`else
                    // Unreachable: the FSM routes this encoding back to FETCH.
                    ALUControl = AluAdd;
`endif
                end
            end
            default: ALUControl = AluAdd;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Moore FSM sequencing the RV32I multi-cycle datapath (shared memory port,
// IR/OldPC pair, registered ALUOut/Data).
// Build option: M_EXT_EN makes funct7=0000001 R-type legal (RV32M); otherwise it
// is treated as an illegal instruction (NOP).
// Ports:
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   OpCode, funct3, funct7     instruction fields from IR
//   Eq, Gt, GtU                ALU comparison flags for branches
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
//   ALUSrcA, ALUSrcB, RegWrite datapath controls
module multi_cycle_control_unit
    import mc_cu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] OpCode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Eq,
    input  logic       Gt,
    input  logic       GtU,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [4:0] ALUControl,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite
);

    state_t     state_q, state_d;
    alu_class_t alu_class;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_class  (alu_class),
        .funct3     (funct3),
        .funct7     (funct7),
        .ALUControl (ALUControl)
    );

    always_comb begin
        state_d   = StFetch;
        alu_class = AluClsAdd;
        PCWrite   = 1'b0;
        AdrSrc    = AdrPc;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = ResAluOut;
        ALUSrcA   = SrcAPc;
        ALUSrcB   = SrcBReg2;
        RegWrite  = 1'b0;

        case (state_q)
            StFetch: begin
                AdrSrc    = AdrPc;
                IRWrite   = 1'b1;
                ALUSrcA   = SrcAPc;
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAluResult;
                PCWrite   = 1'b1;
                state_d   = StDecode;
            end
            StDecode: begin
                // Precompute OldPC+imm so ALUOut holds the branch/JAL target.
                ALUSrcA = SrcAOldPc;
                ALUSrcB = SrcBImm;
                case (OpCode)
                    OpLoad, OpStore: state_d = StMemAdr;
`ifdef M_EXT_EN
                    OpRtype:         state_d = StExecR;
`else
                    OpRtype:         state_d = (funct7 == Funct7MulDiv) ? StFetch : StExecR;
`endif
                    OpItype:         state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr1;
                    OpLui:           state_d = StLui;
                    OpAuipc:         state_d = StAuipc;
                    default:         state_d = StFetch;
                endcase
            end
            StMemAdr: begin
                ALUSrcA = SrcAReg1;
                ALUSrcB = SrcBImm;
                state_d = (OpCode == OpLoad) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                AdrSrc    = AdrResult;
                ResultSrc = ResAluOut;
                state_d   = StMemWb;
            end
            StMemWb: begin
                ResultSrc = ResMemData;
                RegWrite  = 1'b1;
                state_d   = StFetch;
            end
            StMemWrite: begin
                AdrSrc    = AdrResult;
                ResultSrc = ResAluOut;
                MemWrite  = 1'b1;
                state_d   = StFetch;
            end
            StExecR: begin
                ALUSrcA   = SrcAReg1;
                ALUSrcB   = SrcBReg2;
                alu_class = AluClsR;
                state_d   = StAluWb;
            end
            StExecI: begin
                ALUSrcA   = SrcAReg1;
                ALUSrcB   = SrcBImm;
                alu_class = AluClsI;
                state_d   = StAluWb;
            end
            StAluWb: begin
                ResultSrc = ResAluOut;
                RegWrite  = 1'b1;
                state_d   = StFetch;
            end
            StJal, StJalr2: begin
                // PC takes the target already in ALUOut; ALU forms the link value.
                ALUSrcA   = SrcAOldPc;
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAluOut;
                PCWrite   = 1'b1;
                state_d   = StAluWb;
            end
            StJalr1: begin
                ALUSrcA = SrcAReg1;
                ALUSrcB = SrcBImm;
                state_d = StJalr2;
            end
            StBranch: begin
                ALUSrcA   = SrcAReg1;
                ALUSrcB   = SrcBReg2;
                alu_class = AluClsSub;
                ResultSrc = ResAluOut;
                PCWrite   = branch_taken(funct3, Eq, Gt, GtU);
                state_d   = StFetch;
            end
            StLui: begin
                ALUSrcA = SrcAZero;
                ALUSrcB = SrcBImm;
                state_d = StAluWb;
            end
            StAuipc: begin
                ALUSrcA = SrcAOldPc;
                ALUSrcB = SrcBImm;
                state_d = StAluWb;
            end
            default: state_d = StFetch;
        endcase

        // Reset suppresses every architectural write in the cycle it is seen.
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            state_d  = StFetch;
        end
    end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Directed self-checking bench for multi_cycle_control_unit (default build).
// All outputs are packed into one 16-bit word and compared per cycle against
// hand-computed vectors.
module tb_multi_cycle_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] OpCode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Eq, Gt, GtU;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [4:0] ALUControl;

    logic [15:0] outs;
    int checks = 0;
    int errors = 0;

    multi_cycle_control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .OpCode     (OpCode),
        .funct3     (funct3),
        .funct7     (funct7),
        .Eq         (Eq),
        .Gt         (Gt),
        .GtU        (GtU),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .RegWrite   (RegWrite)
    );

    always #5 clk = ~clk;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl, ALUSrcA, ALUSrcB, RegWrite}
    assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
                   ALUSrcA, ALUSrcB, RegWrite};

    function automatic logic [15:0] ov(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs,
                                       input logic [4:0] alu, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic rw);
        return {pcw, adr, mw, irw, rs, alu, sa, sb, rw};
    endfunction

    localparam logic [15:0] VFetch    = ov(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 5'd0, 2'b00, 2'b10, 1'b0);
    localparam logic [15:0] VFetchRst = ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd0, 2'b00, 2'b10, 1'b0);
    localparam logic [15:0] VDecode   = ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b01, 2'b01, 1'b0);
    localparam logic [15:0] VMemAdr   = ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b10, 2'b01, 1'b0);
    localparam logic [15:0] VMemRead  = ov(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 2'b00, 1'b0);
    localparam logic [15:0] VMemWb    = ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 5'd0, 2'b00, 2'b00, 1'b1);
    localparam logic [15:0] VMemWrite = ov(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 5'd0, 2'b00, 2'b00, 1'b0);
    localparam logic [15:0] VExecSub  = ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd1, 2'b10, 2'b00, 1'b0);
    localparam logic [15:0] VExecSrai = ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd7, 2'b10, 2'b01, 1'b0);
    localparam logic [15:0] VExecAddi = ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b10, 2'b01, 1'b0);
    localparam logic [15:0] VAluWb    = ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 2'b00, 1'b1);
    localparam logic [15:0] VBrTaken  = ov(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd1, 2'b10, 2'b00, 1'b0);
    localparam logic [15:0] VBrNot    = ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd1, 2'b10, 2'b00, 1'b0);
    localparam logic [15:0] VJalr1    = ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b10, 2'b01, 1'b0);
    localparam logic [15:0] VJalr2    = ov(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b01, 2'b10, 1'b0);

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] inst);
        OpCode = inst[6:0];
        funct3 = inst[14:12];
        funct7 = inst[31:25];
    endtask

    // Runs a conditional branch through FETCH/DECODE/BRANCH and checks it returns to FETCH.
    task automatic run_branch(input string tag, input logic [31:0] inst, input logic eq,
                              input logic gt, input logic gtu, input logic [15:0] exp_br);
        set_instr(inst);
        Eq = eq; Gt = gt; GtU = gtu;
        check({tag, ".fetch"}, outs, VFetch);
        tick();
        check({tag, ".decode"}, outs, VDecode);
        tick();
        check({tag, ".branch"}, outs, exp_br);
        tick();
        Eq = 1'b0; Gt = 1'b0; GtU = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        Eq = 1'b0; Gt = 1'b0; GtU = 1'b0;
        set_instr(32'h0000_0013);

        // Reset held: FETCH state with every write enable suppressed
        tick();
        check("rst.gated", outs, VFetchRst);
        tick();
        reset = 1'b0;
        #1;

        // lw x1, 4(x2): 5 cycles
        set_instr(32'h0041_2083);
        check("lw.fetch", outs, VFetch);
        tick(); check("lw.decode", outs, VDecode);
        tick(); check("lw.memadr", outs, VMemAdr);
        tick(); check("lw.memread", outs, VMemRead);
        tick(); check("lw.memwb", outs, VMemWb);
        tick();

        // sub x0, x1, x2
        set_instr(32'h4020_8033);
        check("sub.fetch", outs, VFetch);
        tick(); check("sub.decode", outs, VDecode);
        tick(); check("sub.execr", outs, VExecSub);
        tick(); check("sub.aluwb", outs, VAluWb);
        tick();

        // srai x1, x1, 1
        set_instr(32'h4010_D093);
        check("srai.fetch", outs, VFetch);
        tick(); check("srai.decode", outs, VDecode);
        tick(); check("srai.execi", outs, VExecSrai);
        tick(); check("srai.aluwb", outs, VAluWb);
        tick();

        // addi with imm bit 10 set (funct7[5]=1) must still be ADD
        set_instr(32'h4000_8093);
        check("addi.fetch", outs, VFetch);
        tick(); check("addi.decode", outs, VDecode);
        tick(); check("addi.execi", outs, VExecAddi);
        tick(); check("addi.aluwb", outs, VAluWb);
        tick();

        // Branches: beq taken/not, bge taken via Gt, bltu not taken via GtU, f3=010 never
        run_branch("beq_t", 32'h0020_8463, 1'b1, 1'b0, 1'b0, VBrTaken);
        run_branch("beq_n", 32'h0020_8463, 1'b0, 1'b0, 1'b0, VBrNot);
        run_branch("bne_t", 32'h0020_9463, 1'b0, 1'b0, 1'b1, VBrTaken);
        run_branch("bge_t", 32'h0020_D463, 1'b0, 1'b1, 1'b0, VBrTaken);
        run_branch("bltu_n", 32'h0020_E463, 1'b0, 1'b0, 1'b1, VBrNot);
        run_branch("bltu_t", 32'h0020_E463, 1'b0, 1'b1, 1'b0, VBrTaken);
        run_branch("blt_eq", 32'h0020_C463, 1'b1, 1'b0, 1'b0, VBrNot);
        run_branch("br_f3_2", 32'h0020_A463, 1'b1, 1'b1, 1'b1, VBrNot);
        check("br.refetch", outs, VFetch);

        // jalr x1, 0(x1): 5 cycles
        set_instr(32'h0000_80E7);
        check("jalr.fetch", outs, VFetch);
        tick(); check("jalr.decode", outs, VDecode);
        tick(); check("jalr.jalr1", outs, VJalr1);
        tick(); check("jalr.jalr2", outs, VJalr2);
        tick(); check("jalr.aluwb", outs, VAluWb);
        tick();

        // Illegal opcode 0x7F: DECODE then straight back to FETCH
        set_instr(32'h0000_007F);
        check("ill.fetch", outs, VFetch);
        tick(); check("ill.decode", outs, VDecode);
        tick(); check("ill.refetch", outs, VFetch);

        // mul without the M extension is illegal as well
        set_instr(32'h0220_8033);
        tick(); check("mul.decode", outs, VDecode);
        tick(); check("mul.refetch", outs, VFetch);

        // sw x2, 0(x1): reset asserted in MEMADR aborts before MEMWRITE
        set_instr(32'h0020_A023);
        tick(); check("swrst.decode", outs, VDecode);
        tick();
        reset = 1'b1;
        #1;
        check("swrst.memadr", outs, VMemAdr);
        tick();
        check("swrst.fetch_gated", outs, VFetchRst);
        reset = 1'b0;
        #1;
        check("swrst.fetch", outs, VFetch);

        // Same store, uninterrupted: 4 cycles
        tick(); check("sw.decode", outs, VDecode);
        tick(); check("sw.memadr", outs, VMemAdr);
        tick(); check("sw.memwrite", outs, VMemWrite);
        tick(); check("sw.refetch", outs, VFetch);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
